// File: rtl/gradient_orientation.sv
// Streams a full gradient image from x/y BRAMs and writes per-pixel |x|+|y| magnitude and octant orientation.
// Optional feature macro: ORIENTATION_THRESHOLD_EN (zeroes pixels whose magnitude is below MAG_THRESHOLD).
module gradient_orientation #(
    parameter int BIT_DEPTH     = 8,
    parameter int WIDTH         = 64,
    parameter int HEIGHT        = 64,
    parameter int MAG_THRESHOLD = 8
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  start_in,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]       read_addr,
    output logic                                  read_addr_valid,
    input  logic [BIT_DEPTH-1:0]                  x_pixel_in,
    input  logic [BIT_DEPTH-1:0]                  y_pixel_in,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]       write_addr,
    output logic                                  write_valid,
    output logic [BIT_DEPTH-1:0]                  mag_pixel_out,
    output logic [2:0]                            ori_pixel_out,
    output logic                                  done
);
    localparam int AW = $clog2(WIDTH*HEIGHT);
    localparam logic [AW-1:0]        LAST_ADDR = AW'(WIDTH*HEIGHT-1);
    localparam logic [AW-1:0]        ADDR_ONE  = AW'(1);
    localparam logic [BIT_DEPTH:0]   EXT_ONE   = (BIT_DEPTH+1)'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    state_t              state_r, state_next_s;
    logic                v1_r, v2_r;
    logic [AW-1:0]       a1_r, a2_r;
    logic [BIT_DEPTH:0]  abs_x_s, abs_y_s, sum_s;
    logic [BIT_DEPTH-1:0] mag_s;
    logic [2:0]          ori_s;

    // Magnitude of a two's-complement sample, one bit wider so the most negative value is representable
    function automatic logic [BIT_DEPTH:0] abs_ext(input logic [BIT_DEPTH-1:0] v);
        logic [BIT_DEPTH:0] e;
        e = {v[BIT_DEPTH-1], v};
        if (v[BIT_DEPTH-1]) begin
            return (~e) + EXT_ONE;
        end else begin
            return e;
        end
    endfunction

    // Octant from the signs of x/y and which of |x|,|y| dominates
    function automatic logic [2:0] octant(input logic [BIT_DEPTH-1:0] x, input logic [BIT_DEPTH-1:0] y,
                                          input logic [BIT_DEPTH:0] ax, input logic [BIT_DEPTH:0] ay);
        logic xz, yz, xn, yn;
        xz = (x == '0);
        yz = (y == '0);
        xn = x[BIT_DEPTH-1];
        yn = y[BIT_DEPTH-1];
        if (xz && yz) begin
            return 3'd0;
        end else if (!xn && !xz && !yn) begin
            return (ay < ax) ? 3'd0 : 3'd1;
        end else if ((xn || xz) && !yn && !yz) begin
            return (ay > ax) ? 3'd2 : 3'd3;
        end else if (xn && (yn || yz)) begin
            return (ay < ax) ? 3'd4 : 3'd5;
        end else begin
            return (ay > ax) ? 3'd6 : 3'd7;
        end
    endfunction

    // Per-pixel arithmetic on the BRAM data currently presented
    always_comb begin
        abs_x_s = abs_ext(x_pixel_in);
        abs_y_s = abs_ext(y_pixel_in);
        sum_s   = abs_x_s + abs_y_s;
        if (sum_s[BIT_DEPTH]) begin
            mag_s = '1;
        end else begin
            mag_s = sum_s[BIT_DEPTH-1:0];
        end
        ori_s = octant(x_pixel_in, y_pixel_in, abs_x_s, abs_y_s);
    end

    // Pass sequencing
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_in) state_next_s = READ;
                else          state_next_s = IDLE;
            end
            READ: begin
                if (read_addr == LAST_ADDR) state_next_s = DRAIN;
                else                        state_next_s = READ;
            end
            DRAIN: begin
                if (write_valid && (write_addr == LAST_ADDR)) state_next_s = DONE;
                else                                          state_next_s = DRAIN;
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State, read address generator and done pulse
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r         <= IDLE;
            read_addr       <= '0;
            read_addr_valid <= 1'b0;
            done            <= 1'b0;
        end else begin
            state_r <= state_next_s;
            done    <= (state_next_s == DONE);
            if (state_next_s == READ) begin
                read_addr_valid <= 1'b1;
                read_addr       <= (state_r == READ) ? (read_addr + ADDR_ONE) : '0;
            end else begin
                read_addr_valid <= 1'b0;
                read_addr       <= '0;
            end
        end
    end

    // Two-stage address delay matching the BRAM latency, then the registered write port
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            v1_r          <= 1'b0;
            v2_r          <= 1'b0;
            a1_r          <= '0;
            a2_r          <= '0;
            write_valid   <= 1'b0;
            write_addr    <= '0;
            mag_pixel_out <= '0;
            ori_pixel_out <= 3'd0;
        end else begin
            v1_r <= read_addr_valid;
            v2_r <= v1_r;
            a1_r <= read_addr;
            a2_r <= a1_r;
            if (v2_r) begin
                write_valid <= 1'b1;
                write_addr  <= a2_r;
`ifdef ORIENTATION_THRESHOLD_EN
                if (int'(mag_s) < MAG_THRESHOLD) begin
                    mag_pixel_out <= '0;
                    ori_pixel_out <= 3'd0;
                end else begin
                    mag_pixel_out <= mag_s;
                    ori_pixel_out <= ori_s;
                end
`else
                mag_pixel_out <= mag_s;
                ori_pixel_out <= ori_s;
`endif
            end else begin
                write_valid   <= 1'b0;
                write_addr    <= '0;
                mag_pixel_out <= '0;
                ori_pixel_out <= 3'd0;
            end
        end
    end

endmodule

// File: doc/gradient_orientation.md
GRADIENT_ORIENTATION -- requirements
Module: gradient_orientation

Interface
REQ-001 SHALL have parameter BIT_DEPTH, default 8, gradient and magnitude sample width.
REQ-002 SHALL have parameter WIDTH, default 64, image width in pixels.
REQ-003 SHALL have parameter HEIGHT, default 64, image height in pixels.
REQ-004 SHALL have parameter MAG_THRESHOLD, default 8, minimum kept magnitude; used only under ORIENTATION_THRESHOLD_EN.
REQ-005 SHALL have clk_in  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have rst_in  input  1  synchronous, active-high reset.
REQ-007 SHALL have start_in  input  1  one-cycle pulse starting a full-image pass.
REQ-008 SHALL have read_addr  output  $clog2(WIDTH*HEIGHT)  shared address into the x- and y-gradient BRAMs.
REQ-009 SHALL have read_addr_valid  output  1  BRAM enable for read_addr.
REQ-010 SHALL have x_pixel_in  input  BIT_DEPTH  signed two's-complement x gradient; valid 2 cycles after its address.
REQ-011 SHALL have y_pixel_in  input  BIT_DEPTH  signed two's-complement y gradient; same 2-cycle latency.
REQ-012 SHALL have write_addr  output  $clog2(WIDTH*HEIGHT)  output BRAM address.
REQ-013 SHALL have write_valid  output  1  write enable for mag_pixel_out and ori_pixel_out.
REQ-014 SHALL have mag_pixel_out  output  BIT_DEPTH  unsigned magnitude.
REQ-015 SHALL have ori_pixel_out  output  3  orientation octant, 0..7.
REQ-016 SHALL have done  output  1  one-cycle pulse at pass end.

Function
REQ-017 SHALL implement states IDLE, READ, DRAIN, DONE; IDLE->READ on start_in; READ->DRAIN after address WIDTH*HEIGHT-1 issued; DRAIN->DONE after last write; DONE->IDLE next cycle.
REQ-018 SHALL, in READ, issue read_addr 0,1,...,WIDTH*HEIGHT-1 on consecutive cycles with read_addr_valid=1; read_addr_valid=0 in all other states.
REQ-019 SHALL register results so pixel k is written with write_addr=k exactly 3 cycles after read_addr=k is issued; writes consecutive, no gaps.
REQ-020 SHALL compute magnitude as |x|+|y| in BIT_DEPTH+1 bits, saturated to 2^BIT_DEPTH-1 (|-128| = 128 valid).
REQ-021 SHALL compute orientation: x=0,y=0 -> 0; x>0,y>=0 -> (|y|<|x| ? 0 : 1); x<=0,y>0 -> (|y|>|x| ? 2 : 3); x<0,y<=0 -> (|y|<|x| ? 4 : 5); x>=0,y<0 -> (|y|>|x| ? 6 : 7).
REQ-022 SHALL hold write_valid=0 and write_addr, mag_pixel_out, ori_pixel_out at 0 when not writing.
REQ-023 SHALL assert done for exactly one cycle, the cycle after the final write (DONE state).
REQ-024 SHALL ignore start_in outside IDLE; start_in in the DONE cycle is ignored.
REQ-025 SHALL accept a new start_in in IDLE immediately after DONE and repeat the full pass from address 0.

Reset
REQ-026 SHALL, on rst_in=1 at a clock edge, enter IDLE and drive read_addr, read_addr_valid, write_addr, write_valid, mag_pixel_out, ori_pixel_out, done to 0 on the next cycle.
REQ-027 SHALL, on reset mid-pass, abandon the pass: no further writes, no done pulse, pipeline contents discarded.
REQ-028 SHALL give rst_in priority over a coincident start_in.

Configuration
REQ-029 SHALL, with ORIENTATION_THRESHOLD_EN defined, write mag_pixel_out=0 and ori_pixel_out=0 for any pixel whose saturated magnitude < MAG_THRESHOLD, with unchanged latency and write count.
REQ-030 SHALL, without ORIENTATION_THRESHOLD_EN, write every computed magnitude and orientation unmodified and ignore MAG_THRESHOLD.

Verification
REQ-031 SHALL cover: 64x64 BRAM models (2-cycle latency), start_in pulse -> exactly 4096 writes, addrs 0..4095 contiguous, first write 3 cycles after read_addr=0, done one cycle after addr 4095.
REQ-032 SHALL cover: (x,y)=(5,0),(1,1),(0,5),(-1,1),(-5,0),(-1,-1),(0,-5),(1,-1) -> ori 0,1,2,3,4,5,6,7; mag 5,2,5,2,5,2,5,2.
REQ-033 SHALL cover: (x,y)=(-128,-128) -> mag 255, ori 5; (0,0) -> mag 0, ori 0; (100,-100) -> mag 200, ori 7.
REQ-034 SHALL cover: rst_in at cycle 1000 of a pass -> write_valid low from next cycle, no done; new start_in -> full clean pass from address 0.
REQ-035 SHALL cover: start_in pulsed during READ and during DONE -> ignored, still exactly 4096 writes and one done.
REQ-036 SHALL cover: ORIENTATION_THRESHOLD_EN, MAG_THRESHOLD=8, (3,4) -> mag 0, ori 0; (4,4) -> mag 8, ori 1; without macro (3,4) -> mag 7, ori 1.
